// File: rtl/cpu_state_dumper_if.sv
// Snapshot stream from cpu_state_dumper to its sink (UART or debug-host bridge).
// Signal names carry the direction as seen from the dumper.
interface cpu_state_dumper_if #(
    parameter int DATA_W = 32
);
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [DATA_W-1:0] dump_data_o;
    logic [5:0]        dump_idx_o;
    logic              dump_last_o;

    modport master (
        output dump_valid_o, dump_data_o, dump_idx_o, dump_last_o,
        input  dump_ready_i
    );

    modport slave (
        input  dump_valid_o, dump_data_o, dump_idx_o, dump_last_o,
        output dump_ready_i
    );
endinterface

// File: rtl/cpu_state_dumper.sv
// Cycle/stall/flush counters plus an on-request 44-word snapshot stream:
// counters and PC latched at request, registers and data memory read live.
module cpu_state_dumper #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int DATA_W        = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [DATA_W-1:0]   pc_i,
    input  logic                snap_i,
    output logic [4:0]          reg_addr_o,
    input  logic [DATA_W-1:0]   reg_data_i,
    output logic [31:0]         mem_addr_o,
    input  logic [DATA_W-1:0]   mem_data_i,
    cpu_state_dumper_if.master  dump,
    output logic                busy_o,
    output logic [DATA_W-1:0]   cycle_cnt_o,
    output logic [DATA_W-1:0]   stall_cnt_o,
    output logic [DATA_W-1:0]   flush_cnt_o
);

    localparam logic [5:0]        IDX_REG_BASE = 6'd4;
    localparam logic [5:0]        IDX_MEM_BASE = 6'(4 + NUM_REGS);
    localparam logic [5:0]        IDX_LAST     = 6'(4 + NUM_REGS + NUM_MEM_WORDS - 1);
    localparam logic [DATA_W-1:0] CNT_ONE      = DATA_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_REG,
        ST_MEM,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         fetch_idx_q, fetch_idx_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [5:0]         idx_q, idx_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  snap_cycle_q, snap_cycle_d;
    logic [DATA_W-1:0]  snap_stall_q, snap_stall_d;
    logic [DATA_W-1:0]  snap_flush_q, snap_flush_d;
    logic [DATA_W-1:0]  snap_pc_q, snap_pc_d;
    logic [DATA_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic [DATA_W-1:0]  word_sel;
    logic [4:0]         reg_off;
    logic [5:0]         mem_off;
    logic               fetching;
    logic               load;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (start_i) begin
            cycle_cnt_d = cycle_cnt_q + CNT_ONE;
            if (stall_i) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (flush_i) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    // Low five bits suffice: idx 4..35 minus 4 modulo 32 gives R0..R31.
    assign reg_off = fetch_idx_q[4:0] - 5'd4;
    assign mem_off = fetch_idx_q - IDX_MEM_BASE;

    assign reg_addr_o = (state_q == ST_REG) ? reg_off : 5'd0;
    assign mem_addr_o = (state_q == ST_MEM) ? {24'd0, mem_off, 2'b00} : 32'd0;

    always_comb begin
        word_sel = mem_data_i;
        if (fetch_idx_q == 6'd0) begin
            word_sel = snap_cycle_q;
        end else if (fetch_idx_q == 6'd1) begin
            word_sel = snap_stall_q;
        end else if (fetch_idx_q == 6'd2) begin
            word_sel = snap_flush_q;
        end else if (fetch_idx_q == 6'd3) begin
            word_sel = snap_pc_q;
        end else if (fetch_idx_q < IDX_MEM_BASE) begin
            word_sel = reg_data_i;
        end
    end

    assign fetching = (state_q == ST_HDR) || (state_q == ST_REG) || (state_q == ST_MEM);
    assign load     = fetching && (!valid_q || dump.dump_ready_i);

    always_comb begin
        state_d      = state_q;
        fetch_idx_d  = fetch_idx_q;
        valid_d      = valid_q;
        data_d       = data_q;
        idx_d        = idx_q;
        last_d       = last_q;
        snap_cycle_d = snap_cycle_q;
        snap_stall_d = snap_stall_q;
        snap_flush_d = snap_flush_q;
        snap_pc_d    = snap_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                // Counters are captured before this edge's increment lands.
                if (snap_i) begin
                    state_d      = ST_HDR;
                    fetch_idx_d  = 6'd0;
                    snap_cycle_d = cycle_cnt_q;
                    snap_stall_d = stall_cnt_q;
                    snap_flush_d = flush_cnt_q;
                    snap_pc_d    = pc_i;
                end
            end
            ST_HDR, ST_REG, ST_MEM: begin
                if (load) begin
                    valid_d     = 1'b1;
                    data_d      = word_sel;
                    idx_d       = fetch_idx_q;
                    last_d      = (fetch_idx_q == IDX_LAST);
                    fetch_idx_d = fetch_idx_q + 6'd1;
                    if (fetch_idx_q == IDX_REG_BASE - 6'd1) begin
                        state_d = ST_REG;
                    end else if (fetch_idx_q == IDX_MEM_BASE - 6'd1) begin
                        state_d = ST_MEM;
                    end else if (fetch_idx_q == IDX_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (valid_q && dump.dump_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            fetch_idx_q  <= 6'd0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            idx_q        <= 6'd0;
            last_q       <= 1'b0;
            snap_cycle_q <= '0;
            snap_stall_q <= '0;
            snap_flush_q <= '0;
            snap_pc_q    <= '0;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_idx_q  <= fetch_idx_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            snap_cycle_q <= snap_cycle_d;
            snap_stall_q <= snap_stall_d;
            snap_flush_q <= snap_flush_d;
            snap_pc_q    <= snap_pc_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign dump.dump_valid_o = valid_q;
    assign dump.dump_data_o  = data_q;
    assign dump.dump_idx_o   = idx_q;
    assign dump.dump_last_o  = last_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign cycle_cnt_o       = cycle_cnt_q;
    assign stall_cnt_o       = stall_cnt_q;
    assign flush_cnt_o       = flush_cnt_q;

endmodule

// File: doc/cpu_state_dumper.md
# cpu_state_dumper

Hardware source for the per-cycle trace data the simulation bench prints: it counts cycles, stalls and flushes, and on request streams a snapshot out on a valid/ready port. The snapshot holds PC, all 32 registers and data memory words 0x00–0x1c. It sits beside the pipelined CPU. It reads the register file and data memory through dedicated combinational read ports, and its stream feeds a UART or debug-host bridge.

## Interface
- NUM_REGS, 32, register-file entries dumped
- NUM_MEM_WORDS, 8, 32-bit data-memory words dumped, starting at byte 0x00
- DATA_W, 32, word width of counters, PC and stream data

- clk_i  in  1  single clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  CPU running; gates all counters
- stall_i  in  1  one-cycle pulse, pipeline stalled this cycle
- flush_i  in  1  one-cycle pulse, IF/ID flushed this cycle
- pc_i  in  32  current PC value
- snap_i  in  1  dump request; sampled only in IDLE
- reg_addr_o  out  5  register-file read address
- reg_data_i  in  32  combinational read data for reg_addr_o
- mem_addr_o  out  32  data-memory byte address, word aligned
- mem_data_i  in  32  combinational little-endian word at mem_addr_o
- dump_valid_o  out  1  dump_data_o holds a valid word
- dump_ready_i  in  1  sink accepts the word this cycle
- dump_data_o  out  32  stream word
- dump_idx_o  out  6  index of the current word, 0..43
- dump_last_o  out  1  high with word 43
- busy_o  out  1  dump in progress
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  32 each  live counters

## Operation
- **Counters.**
  - cycle_cnt increments on every edge with start_i=1.
  - stall_cnt increments when start_i & stall_i.
  - flush_cnt increments when start_i & flush_i.
  - All three wrap modulo 2^32.
  - Stall and flush may increment in the same cycle.
- **Record layout.** Each dump is 44 words:
  - idx 0 = cycle snapshot
  - idx 1 = stall snapshot
  - idx 2 = flush snapshot
  - idx 3 = PC snapshot
  - idx 4..35 = R0..R31
  - idx 36..43 = mem words at byte address (idx-36)*4
- **Snapshot.** Counters and PC are latched on the edge that accepts snap_i. Registers and memory are read live during the dump. The CPU is not halted; stalling it is the integrator's responsibility.
- **FSM states.** IDLE, HDR (idx 0–3), REG (4–35), MEM (36–43), DRAIN.
  - IDLE→HDR: snap_i=1.
  - HDR→REG, REG→MEM: when the fetch index crosses the boundary.
  - MEM→DRAIN: after word 43 is loaded into the output register.
  - DRAIN→IDLE: when word 43 handshakes.
  - snap_i while not in IDLE is ignored and not queued.
- **Fetch and output.**
  - A fetch index selects the word source.
  - reg_addr_o = idx-4 in REG, else 0.
  - mem_addr_o = (idx-36)<<2 in MEM, else 0.
  - The output register loads when (!dump_valid_o | dump_ready_i). On a load, the fetch index advances.
  - While dump_valid_o & !dump_ready_i, dump_data_o, dump_idx_o and dump_last_o are held stable. Valid must not drop before the handshake.
- **busy_o** is high from the snap-accept edge until the word-43 handshake edge, inclusive of DRAIN.

## Timing
- **Reset values:** all counters 0, dump_valid_o 0, dump_data_o 0, dump_idx_o 0, dump_last_o 0, busy_o 0, addresses 0, state IDLE.
- **Latency:**
  - snap_i high at edge N: busy_o=1 after edge N.
  - Word 0 is valid after edge N+1.
  - With dump_ready_i held 1, one word is transferred per cycle. Word 43 handshakes at edge N+45, and busy_o=0 after it.
- **Back-to-back dumps:** snap_i high in the cycle after busy_o falls is accepted.
- **Reset mid-dump:** rst_i at any edge aborts the dump. The block returns to IDLE with outputs at reset values after that edge, and counters clear.
- **Counter snapshot edge:** the counter value latched is the value before that edge's increment.

## Test plan
- **Counting.** Reset, then start_i=1 for 20 cycles with stall_i pulsed on 3 cycles and flush_i on 2 (one overlapping a stall) -> cycle=20, stall=3, flush=2.
- **Full dump, ready tied high.**
  - Stimulus: preload R8=5, R31=0xFFFF_FFFF, mem word 0x00=5, word 0x1c=0x1234_5678; snap_i at cycle 10 with pc_i=40.
  - Response: 44 consecutive words; idx3=40, idx12=5, idx35=0xFFFF_FFFF, idx36=5, idx43=0x1234_5678; dump_last_o only on idx 43; busy_o high for exactly 45 cycles.
- **Backpressure.** Random dump_ready_i at 30% -> data and idx stable whenever valid&!ready; no word dropped or duplicated; idx sequence 0..43.
- **Ignored request.** snap_i pulsed at idx 20 -> no restart, single 44-word record.
- **Reset mid-dump.** rst_i at idx 17 -> valid=0, busy=0, counters=0 next cycle; a new snap_i then yields a complete record starting at idx 0.
- **Wrap.** Force cycle_cnt=0xFFFF_FFFF, run 1 cycle -> cycle_cnt=0.
